// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage state type.
// ALU control and the execute stage both decode from these definitions.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_exec_stage_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done and product are combinational on the final step so the caller can register them at that edge.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   step;
    logic                 last;

    // Upper half accumulates the multiplicand; lower half holds the remaining multiplier bits.
    always_comb begin
        sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : {WIDTH{1'b0}})};
        step = {sum, p_q[WIDTH-1:1]};
        last = busy_q && (cnt_q == CW'(WIDTH-1));
    end

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        a_d    = a_q;
        p_d    = p_q;
        if (start) begin
            a_d    = a;
            p_d    = {{WIDTH{1'b0}}, b};
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            p_d   = step;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            a_q    <= '0;
            p_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            a_q    <= a_d;
            p_q    <= p_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last;
    assign product = step;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative MUL, with a
// registered valid/ready result toward writeback.
//
//   state | meaning
//   IDLE  | accepting ops whenever the output slot is free or being drained
//   MUL   | multiplier iterating; input side stalled
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Illegal
);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ALUctl)
            ALU_AND: alu_res = A & B;
            ALU_OR:  alu_res = A | B;
            ALU_ADD: alu_res = A + B;
            ALU_SUB: alu_res = A - B;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_NOR: alu_res = ~(A | B);
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mul_start) state_d = MUL;
            MUL:  if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !mul_busy && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        mul_start = accept && (ALUctl == ALU_MUL);

        // A consumed result drops unless something new lands at the same edge.
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;

        if (state_q == MUL) begin
            if (mul_done) begin
                out_valid_d = 1'b1;
                result_d    = mul_product[WIDTH-1:0];
                result_hi_d = mul_product[2*WIDTH-1:WIDTH];
                zero_d      = (mul_product[WIDTH-1:0] == '0);
                illegal_d   = 1'b0;
            end
        end else if (accept && !mul_start) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            illegal_d   = alu_ill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign ResultHi  = result_hi_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: transaction-level reference model checked every
// cycle, plus literal expectations on the key vectors.
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     ALUctl = 4'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   Result;
    logic [W-1:0]   ResultHi;
    logic           Zero;
    logic           Illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUctl    (ALUctl),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .ResultHi  (ResultHi),
        .Zero      (Zero),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one result slot, and a MUL that lands WIDTH edges after acceptance.
    logic           m_valid = 1'b0;
    logic [W-1:0]   m_res = '0;
    logic [W-1:0]   m_hi = '0;
    logic           m_zero = 1'b0;
    logic           m_ill = 1'b0;
    int             m_left = 0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk or posedge rst) begin
        logic rdy;
        if (rst) begin
            m_valid = 1'b0; m_res = '0; m_hi = '0; m_zero = 1'b0; m_ill = 1'b0;
            m_left = 0;
        end else begin
            rdy = (m_left == 0) && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = m_prod[W-1:0]; m_hi = m_prod[2*W-1:W];
                    m_zero = (m_res == 0); m_ill = 1'b0; m_valid = 1'b1;
                end
            end else if (in_valid && rdy) begin
                if (ALUctl == ALU_MUL) begin
                    m_prod = (2*W)'(A) * (2*W)'(B);
                    m_left = W;
                end else begin
                    m_ill = 1'b0;
                    case (ALUctl)
                        ALU_AND: m_res = A & B;
                        ALU_OR:  m_res = A | B;
                        ALU_ADD: m_res = W'(A + B);
                        ALU_SUB: m_res = W'(A - B);
                        ALU_SLT: m_res = ($signed(A) < $signed(B)) ? 1 : 0;
                        ALU_NOR: m_res = ~(A | B);
                        default: begin m_res = 0; m_ill = 1'b1; end
                    endcase
                    m_hi = 0; m_zero = (m_res == 0); m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        cmp("in_ready",  in_ready,  (m_left == 0) && (!m_valid || out_ready));
        cmp("out_valid", out_valid, m_valid);
        cmp("Result",    Result,    m_res);
        cmp("ResultHi",  ResultHi,  m_hi);
        cmp("Zero",      Zero,      m_zero);
        cmp("Illegal",   Illegal,   m_ill);
    end

    // Present an op and return #1 after the edge that accepts it; in_valid is left asserted.
    task automatic send(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        logic rdy_s;
        bit   took = 0;
        in_valid = 1'b1; ALUctl = ctl; A = a; B = b;
        for (int i = 0; i < 200; i++) begin
            #0 rdy_s = in_ready;
            @(posedge clk);
            if (rdy_s) begin took = 1; break; end
        end
        #1;
        if (!took) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: op 0x%0h not accepted within 200 cycles", ctl);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit saw_valid;
        #2 rst = 1'b1;
        tick(3);
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_Result",    Result,    0);
        cmp("rst_in_ready",  in_ready,  1);
        rst = 1'b0;
        tick(1);

        // Back-to-back single-cycle ops
        out_ready = 1'b1;
        send(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
        cmp("add_Result", Result, 0);
        cmp("add_Zero",   Zero,   1);
        cmp("add_valid",  out_valid, 1);
        send(ALU_SUB, 32'd5, 32'd7);
        cmp("sub_Result", Result, 64'hFFFF_FFFE);
        cmp("sub_Zero",   Zero,   0);
        send(ALU_SLT, 32'hFFFF_FFFE, 32'h1);
        cmp("slt_Result", Result, 1);
        send(ALU_SLT, 32'h1, 32'hFFFF_FFFE);
        cmp("slt_rev_Result", Result, 0);
        cmp("slt_rev_Zero",   Zero,   1);
        idle();
        tick(2);
        cmp("drain_valid", out_valid, 0);

        // Full-width MUL
        send(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle();
        for (int k = 1; k < W; k++) begin
            cmp("mul_busy_in_ready", in_ready, 0);
            cmp("mul_busy_valid",    out_valid, 0);
            tick(1);
        end
        cmp("mul_pre_valid", out_valid, 0);
        tick(1);
        cmp("mul_valid",    out_valid, 1);
        cmp("mul_ResultHi", ResultHi,  64'hFFFF_FFFE);
        cmp("mul_Result",   Result,    64'h1);
        cmp("mul_Zero",     Zero,      0);

        // Small MUL, then a single-cycle op clears ResultHi
        send(ALU_MUL, 32'd7, 32'd9);
        idle();
        tick(W);
        cmp("mul7x9_Result", Result, 63);
        cmp("mul7x9_Hi",     ResultHi, 0);
        send(ALU_OR, 32'h0, 32'h0);
        idle();
        cmp("or0_Hi",   ResultHi, 0);
        cmp("or0_Zero", Zero, 1);
        tick(2);

        // Backpressure with a pending op
        out_ready = 1'b0;
        send(ALU_AND, 32'hF0F0, 32'h0FF0);
        in_valid = 1'b1; ALUctl = ALU_OR; A = 32'd1; B = 32'd2;
        for (int k = 0; k < 4; k++) begin
            cmp("bp_Result",   Result,   32'h00F0);
            cmp("bp_in_ready", in_ready, 0);
            cmp("bp_valid",    out_valid, 1);
            tick(1);
        end
        out_ready = 1'b1;
        send(ALU_OR, 32'd1, 32'd2);
        cmp("bp_or_Result", Result, 3);
        cmp("bp_or_valid",  out_valid, 1);

        // Illegal code then NOR
        send(4'b1111, 32'd5, 32'd5);
        cmp("ill_Result",  Result,  0);
        cmp("ill_Zero",    Zero,    1);
        cmp("ill_Illegal", Illegal, 1);
        send(ALU_NOR, 32'h0, 32'h0);
        cmp("nor_Result",  Result,  64'hFFFF_FFFF);
        cmp("nor_Illegal", Illegal, 0);
        idle();
        tick(2);

        // Reset in the middle of a MUL
        send(ALU_MUL, 32'd7, 32'd9);
        idle();
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        cmp("rstmul_valid",    out_valid, 0);
        cmp("rstmul_Result",   Result,    0);
        cmp("rstmul_in_ready", in_ready,  1);
        saw_valid = 0;
        for (int k = 0; k < 2*W; k++) begin
            tick(1);
            if (out_valid) saw_valid = 1;
        end
        cmp("rstmul_no_product", saw_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
